// File: rtl/mac_pkg.sv
// Shared MAC definitions: framer states, Ethernet framing constants, CRC-32 constants.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  localparam int unsigned BYTE_CNT_W = 11;
  localparam int unsigned AUX_CNT_W  = 8;

  // FCS byte idx (0 = first on the wire) of the complemented running CRC.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    fcs      = ~crc;
    fcs_byte = 8'(fcs >> {idx, 3'b000});
  endfunction

endpackage

// File: rtl/crc32_byte.sv
// One-byte step of the reflected IEEE 802.3 CRC-32 (LSB of the byte first).
module crc32_byte
  import mac_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next_c
);

  // Eight serial LFSR steps unrolled into one combinational stage.
  always_comb begin
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_next_c = c;
  end

endmodule

// File: rtl/mac_tx_framer.sv
// Transmit framer: preamble/SFD, payload, zero pad, FCS, then a forced inter-frame gap.
module mac_tx_framer
  import mac_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_FRAME    = 60,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       tx_er,
  output logic       tx_done,
  output logic       busy
);

  localparam int unsigned CMP_W = BYTE_CNT_W + 1;

  localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = '1;
  localparam logic [CMP_W-1:0]      MIN_FRAME_W  = CMP_W'(MIN_FRAME);
  localparam logic [AUX_CNT_W-1:0]  PRE_LAST     = AUX_CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [AUX_CNT_W-1:0]  IFG_LAST     = AUX_CNT_W'(IFG_BYTES - 1);
  localparam logic [AUX_CNT_W-1:0]  FCS_LAST     = AUX_CNT_W'(3);
  localparam tx_state_t             FIRST_STATE  = (PREAMBLE_LEN > 1) ? PRE : SFD;
  localparam tx_state_t             END_STATE    = (IFG_BYTES == 0) ? IDLE : IFG;

  tx_state_t             state_q, state_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [AUX_CNT_W-1:0]  aux_q, aux_d;
  logic [31:0]           crc_q, crc_d;
  logic [31:0]           crc_upd_c;
  logic [7:0]            crc_in_c;
  logic [CMP_W-1:0]      byte_inc_c;
  logic [BYTE_CNT_W-1:0] byte_sat_c;
  logic [7:0]            tx_data_d;
  logic                  tx_en_d, tx_er_d, tx_done_d;

  // Pad bytes are zeros; everything else folded into the CRC is the accepted payload byte.
  assign crc_in_c   = (state_q == PAD) ? 8'h00 : s_data;
  assign byte_inc_c = CMP_W'(byte_cnt_q) + CMP_W'(1);
  assign byte_sat_c = (byte_cnt_q == BYTE_CNT_MAX) ? BYTE_CNT_MAX : byte_cnt_q + BYTE_CNT_W'(1);

  crc32_byte u_crc (
    .crc        (crc_q),
    .data       (crc_in_c),
    .crc_next_c (crc_upd_c)
  );

  assign s_ready = (state_q == DATA);
  assign busy    = (state_q != IDLE);

  // Next state, counters, CRC and the byte to register toward the serializer.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    aux_d      = aux_q;
    crc_d      = crc_q;
    tx_data_d  = 8'h00;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    tx_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The first preamble byte goes out on the cycle after s_valid is seen.
        if (s_valid) begin
          tx_data_d = ETH_PREAMBLE;
          tx_en_d   = 1'b1;
          aux_d     = AUX_CNT_W'(1);
          state_d   = FIRST_STATE;
        end
      end
      PRE: begin
        tx_data_d = ETH_PREAMBLE;
        tx_en_d   = 1'b1;
        aux_d     = aux_q + AUX_CNT_W'(1);
        if (aux_q == PRE_LAST) state_d = SFD;
      end
      SFD: begin
        tx_data_d  = ETH_SFD;
        tx_en_d    = 1'b1;
        crc_d      = CRC32_INIT;
        byte_cnt_d = '0;
        aux_d      = '0;
        state_d    = DATA;
      end
      DATA: begin
        tx_en_d = 1'b1;
        if (s_valid) begin
          tx_data_d  = s_data;
          crc_d      = crc_upd_c;
          byte_cnt_d = byte_sat_c;
          if (s_last) begin
            aux_d   = '0;
            state_d = (byte_inc_c < MIN_FRAME_W) ? PAD : FCS;
          end
        end else begin
          // Underrun: mark the byte as errored and close the frame without an FCS.
          tx_er_d   = 1'b1;
          tx_done_d = 1'b1;
          aux_d     = '0;
          state_d   = END_STATE;
        end
      end
      PAD: begin
        tx_en_d    = 1'b1;
        crc_d      = crc_upd_c;
        byte_cnt_d = byte_sat_c;
        if (byte_inc_c == MIN_FRAME_W) state_d = FCS;
      end
      FCS: begin
        tx_data_d = fcs_byte(crc_q, aux_q[1:0]);
        tx_en_d   = 1'b1;
        aux_d     = aux_q + AUX_CNT_W'(1);
        if (aux_q == FCS_LAST) begin
          tx_done_d = 1'b1;
          aux_d     = '0;
          state_d   = END_STATE;
        end
      end
      IFG: begin
        aux_d = aux_q + AUX_CNT_W'(1);
        if (aux_q == IFG_LAST) begin
          aux_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, CRC and registered transmit outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      aux_q      <= '0;
      crc_q      <= CRC32_INIT;
      tx_data    <= 8'h00;
      tx_en      <= 1'b0;
      tx_er      <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      aux_q      <= aux_d;
      crc_q      <= crc_d;
      tx_data    <= tx_data_d;
      tx_en      <= tx_en_d;
      tx_er      <= tx_er_d;
      tx_done    <= tx_done_d;
    end
  end

endmodule
